// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM state encoding and two-word opcode patterns for the fetch unit.
package fetch_unit_pkg;

  localparam int unsigned pkg_size_inst = 16;
  localparam int unsigned pkg_size_fm   = 8;

  typedef enum logic {
    FETCH1 = 1'b0,
    FETCH2 = 1'b1
  } fetch_state_e;

  // Mask/match pairs for the opcodes that carry a second word.
  localparam logic [15:0] jmp_mask   = 16'hFE0E;
  localparam logic [15:0] jmp_match  = 16'h940C;
  localparam logic [15:0] call_mask  = 16'hFE0E;
  localparam logic [15:0] call_match = 16'h940E;
  localparam logic [15:0] lds_mask   = 16'hFE0F;
  localparam logic [15:0] lds_match  = 16'h9000;
  localparam logic [15:0] sts_mask   = 16'hFE0F;
  localparam logic [15:0] sts_match  = 16'h9200;

endpackage

// File: rtl/fetch_unit_two_word_detect.sv
// Combinational classifier: flags instruction words that are followed by a second word.
module two_word_detect
  import fetch_unit_pkg::*;
#(
  parameter int unsigned size_inst = pkg_size_inst
) (
  input  logic [size_inst-1:0] inst,
  output logic                 is_two_word_c
);

  logic [15:0] word;

  assign word = 16'(inst);

  // Match against the JMP, CALL, LDS and STS encodings.
  always_comb begin
    is_two_word_c = 1'b0;
    if (((word & jmp_mask)  == jmp_match)  ||
        ((word & call_mask) == call_match) ||
        ((word & lds_mask)  == lds_match)  ||
        ((word & sts_mask)  == sts_match)) begin
      is_two_word_c = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks the program flash and assembles one- and two-word instructions.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned size_inst = pkg_size_inst,
  parameter int unsigned size_fm   = pkg_size_fm
) (
  input  logic                 clk_fu,
  input  logic                 rst_fu,
  input  logic                 E,
  input  logic                 stall,
  input  logic                 br_valid,
  input  logic [size_fm-1:0]   br_target,
  output logic [size_fm-1:0]   Fetch_adress,
  input  logic [size_inst-1:0] In_inst,
  output logic [size_inst-1:0] Out_inst,
  output logic [size_inst-1:0] Out_k,
  output logic [size_fm-1:0]   Out_pc,
  output logic                 two_word,
  output logic                 inst_valid
);

  fetch_state_e       state;
  logic [size_fm-1:0] pc;
  logic               is_two_word_c;

  two_word_detect #(
    .size_inst(size_inst)
  ) u_detect (
    .inst         (In_inst),
    .is_two_word_c(is_two_word_c)
  );

  assign Fetch_adress = pc;

  // PC, FSM and output registers with priority reset > redirect > disable > stall > fetch.
  always_ff @(posedge clk_fu) begin
    if (rst_fu) begin
      state      <= FETCH1;
      pc         <= '0;
      Out_inst   <= '0;
      Out_k      <= '0;
      Out_pc     <= '0;
      two_word   <= 1'b0;
      inst_valid <= 1'b0;
    end else if (br_valid) begin
      state      <= FETCH1;
      pc         <= br_target;
      two_word   <= 1'b0;
      inst_valid <= 1'b0;
    end else if (!E) begin
      inst_valid <= 1'b0;
    end else if (!stall) begin
      pc <= pc + size_fm'(1);
      case (state)
        FETCH1: begin
          Out_inst <= In_inst;
          Out_pc   <= pc;
          if (is_two_word_c) begin
            state      <= FETCH2;
            two_word   <= 1'b1;
            inst_valid <= 1'b0;
          end else begin
            two_word   <= 1'b0;
            Out_k      <= '0;
            inst_valid <= 1'b1;
          end
        end
        FETCH2: begin
          state      <= FETCH1;
          Out_k      <= In_inst;
          inst_valid <= 1'b1;
        end
        default: state <= FETCH1;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, wrap sequence, random run vs model.
module tb_fetch_unit;

  logic        clk_fu;
  logic        rst_fu;
  logic        E;
  logic        stall;
  logic        br_valid;
  logic [7:0]  br_target;
  logic [7:0]  Fetch_adress;
  logic [15:0] In_inst;
  logic [15:0] Out_inst;
  logic [15:0] Out_k;
  logic [7:0]  Out_pc;
  logic        two_word;
  logic        inst_valid;

  logic [15:0] mem [256];

  int total;
  int bad;

  fetch_unit dut (
    .clk_fu      (clk_fu),
    .rst_fu      (rst_fu),
    .E           (E),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .Fetch_adress(Fetch_adress),
    .In_inst     (In_inst),
    .Out_inst    (Out_inst),
    .Out_k       (Out_k),
    .Out_pc      (Out_pc),
    .two_word    (two_word),
    .inst_valid  (inst_valid)
  );

  // Flash model: combinational read at the fetch address.
  assign In_inst = mem[Fetch_adress];

  initial begin
    clk_fu = 1'b0;
    forever #5 clk_fu = ~clk_fu;
  end

  typedef struct {
    bit          rst;
    bit          e;
    bit          st;
    bit          br;
    logic [7:0]  tgt;
    logic [7:0]  fa;
    bit          iv;
    logic [15:0] oi;
    logic [15:0] ok;
    logic [7:0]  opc;
    bit          tw;
  } vec_t;

  // Expected state of the fetch stage at instruction level.
  typedef struct {
    int          pc;
    bit          half;
    logic [15:0] oi;
    logic [15:0] ok;
    int          opc;
    bit          tw;
    bit          iv;
  } model_t;

  model_t m;
  vec_t   vt [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_long(input logic [15:0] w);
    return (w ==? 16'b1001_010?_????_110?) || (w ==? 16'b1001_010?_????_111?) ||
           (w ==? 16'b1001_000?_????_0000) || (w ==? 16'b1001_001?_????_0000);
  endfunction

  // Advance the model by one clock edge given the inputs and current flash contents.
  task automatic model_step(input bit r, input bit e, input bit st, input bit br, input int tgt);
    logic [15:0] w;
    if (r) begin
      m = '{pc: 0, half: 0, oi: 16'h0, ok: 16'h0, opc: 0, tw: 0, iv: 0};
    end else if (br) begin
      m.pc = tgt; m.half = 0; m.iv = 0; m.tw = 0;
    end else if (!e) begin
      m.iv = 0;
    end else if (!st) begin
      w = mem[m.pc];
      if (!m.half) begin
        m.oi = w; m.opc = m.pc;
        if (is_long(w)) begin m.half = 1; m.iv = 0; m.tw = 1; end
        else begin m.iv = 1; m.tw = 0; m.ok = 16'h0; end
      end else begin
        m.ok = w; m.iv = 1; m.half = 0;
      end
      m.pc = (m.pc + 1) % 256;
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit st, input bit br, input logic [7:0] tgt);
    rst_fu = r; E = e; stall = st; br_valid = br; br_target = tgt;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".Fetch_adress"}, 32'(Fetch_adress), 32'(v.fa));
    chk({tag, ".inst_valid"},   32'(inst_valid),   32'(v.iv));
    chk({tag, ".Out_inst"},     32'(Out_inst),     32'(v.oi));
    chk({tag, ".Out_k"},        32'(Out_k),        32'(v.ok));
    chk({tag, ".Out_pc"},       32'(Out_pc),       32'(v.opc));
    chk({tag, ".two_word"},     32'(two_word),     32'(v.tw));
  endtask

  initial begin
    vec_t v;
    int   r;
    total = 0;
    bad   = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    foreach (mem[i]) mem[i] = 16'h0D11;
    mem[0] = 16'h210E; mem[1] = 16'h0D11; mem[2] = 16'h210E;
    mem[3] = 16'h940C; mem[4] = 16'h0040; mem[5] = 16'h0D11;
    mem[6] = 16'h9000; mem[7] = 16'h5555;
    mem[8'h80] = 16'h1111; mem[8'h81] = 16'h940E; mem[8'h82] = 16'h7777;

    //          rst e  st br tgt     fa     iv oi        ok        opc    tw
    vt[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 0};
    vt[1]  = '{0, 1, 0, 0, 8'h00, 8'h01, 1, 16'h210E, 16'h0000, 8'h00, 0};
    vt[2]  = '{0, 1, 0, 0, 8'h00, 8'h02, 1, 16'h0D11, 16'h0000, 8'h01, 0};
    vt[3]  = '{0, 1, 0, 0, 8'h00, 8'h03, 1, 16'h210E, 16'h0000, 8'h02, 0};
    vt[4]  = '{0, 1, 0, 0, 8'h00, 8'h04, 0, 16'h940C, 16'h0000, 8'h03, 1};
    vt[5]  = '{0, 1, 0, 0, 8'h00, 8'h05, 1, 16'h940C, 16'h0040, 8'h03, 1};
    vt[6]  = '{0, 1, 1, 0, 8'h00, 8'h05, 1, 16'h940C, 16'h0040, 8'h03, 1};
    vt[7]  = '{0, 1, 1, 0, 8'h00, 8'h05, 1, 16'h940C, 16'h0040, 8'h03, 1};
    vt[8]  = '{0, 1, 1, 0, 8'h00, 8'h05, 1, 16'h940C, 16'h0040, 8'h03, 1};
    vt[9]  = '{0, 1, 0, 0, 8'h00, 8'h06, 1, 16'h0D11, 16'h0000, 8'h05, 0};
    vt[10] = '{0, 0, 0, 0, 8'h00, 8'h06, 0, 16'h0D11, 16'h0000, 8'h05, 0};
    vt[11] = '{0, 1, 0, 0, 8'h00, 8'h07, 0, 16'h9000, 16'h0000, 8'h06, 1};
    vt[12] = '{0, 1, 1, 1, 8'h80, 8'h80, 0, 16'h9000, 16'h0000, 8'h06, 0};
    vt[13] = '{0, 1, 0, 0, 8'h00, 8'h81, 1, 16'h1111, 16'h0000, 8'h80, 0};
    vt[14] = '{0, 1, 0, 0, 8'h00, 8'h82, 0, 16'h940E, 16'h0000, 8'h81, 1};
    vt[15] = '{1, 1, 0, 0, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 0};
    vt[16] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 0};
    vt[17] = '{0, 1, 1, 0, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 0};
    vt[18] = '{1, 1, 1, 0, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 0};
    vt[19] = '{0, 1, 0, 0, 8'h00, 8'h01, 1, 16'h210E, 16'h0000, 8'h00, 0};

    @(posedge clk_fu); #1;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].rst, vt[i].e, vt[i].st, vt[i].br, vt[i].tgt);
      @(posedge clk_fu); #1;
      check_vec($sformatf("vec%0d", i), vt[i]);
    end

    // Two-word instruction straddling the top of the address space.
    mem[8'hFF] = 16'h9200; mem[8'h00] = 16'h1234; mem[8'h01] = 16'h0D11;
    drive(0, 0, 0, 1, 8'hFF);
    @(posedge clk_fu); #1;
    v = '{0, 0, 0, 1, 8'hFF, 8'hFF, 0, 16'h210E, 16'h0000, 8'h00, 0};
    check_vec("wrap_br", v);
    drive(0, 1, 0, 0, 8'h00);
    @(posedge clk_fu); #1;
    v = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 16'h9200, 16'h0000, 8'hFF, 1};
    check_vec("wrap_w1", v);
    @(posedge clk_fu); #1;
    v = '{0, 1, 0, 0, 8'h00, 8'h01, 1, 16'h9200, 16'h1234, 8'hFF, 1};
    check_vec("wrap_w2", v);

    // Random run against the model with two-word opcodes seeded into flash.
    foreach (mem[i]) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0: mem[i] = 16'h940C | (16'($urandom) & 16'h01F1);
        1: mem[i] = 16'h940E | (16'($urandom) & 16'h01F1);
        2: mem[i] = 16'h9000 | (16'($urandom) & 16'h01F0);
        3: mem[i] = 16'h9200 | (16'($urandom) & 16'h01F0);
        default: mem[i] = 16'($urandom);
      endcase
    end
    for (int c = 0; c < 3000; c++) begin
      bit          rr, ee, ss, bb;
      logic [7:0]  tt;
      rr = (c == 0) || ($urandom_range(0, 63) == 0);
      ee = ($urandom_range(0, 7) != 0);
      ss = ($urandom_range(0, 5) == 0);
      bb = ($urandom_range(0, 15) == 0);
      tt = 8'($urandom);
      drive(rr, ee, ss, bb, tt);
      model_step(rr, ee, ss, bb, int'(tt));
      @(posedge clk_fu); #1;
      v = '{rr, ee, ss, bb, tt, 8'(m.pc), m.iv, m.oi, m.ok, 8'(m.opc), m.tw};
      check_vec($sformatf("rnd%0d", c), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
